// File: rtl/riscv_div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the iteration.
module riscv_div_unit #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);
    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic           sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic           div0_q, div0_d, ovf_q, ovf_d;
    logic [N-1:0]   dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d, result_q, result_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           is_signed, in_div0, in_ovf, launch;
    logic [N-1:0]   mag_a, mag_b, q_out, r_out, fix_out;
    logic [N:0]     rem_sh, diff;

    assign is_signed = ~op[0];
    assign in_div0   = (divisor == '0);
    assign in_ovf    = is_signed && (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
    assign mag_a     = (is_signed && dividend[N-1]) ? -dividend : dividend;
    assign mag_b     = (is_signed && divisor[N-1]) ? -divisor : divisor;
    assign launch    = start && !flush && (state_q == StIdle || state_q == StDone);

    // N+1-bit trial subtraction: diff[N] is the borrow.
    assign rem_sh = {rem_q, quo_q[N-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    // On the fast paths quo_q still holds the dividend magnitude.
    always_comb begin
        q_out = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
        r_out = sign_a_q ? -rem_q : rem_q;
        if (div0_q) begin
            q_out = '1;
            r_out = sign_a_q ? -quo_q : quo_q;
        end else if (ovf_q) begin
            q_out = {1'b1, {(N-1){1'b0}}};
            r_out = '0;
        end
        fix_out = op_q[1] ? r_out : q_out;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (launch) begin
                    op_d     = op;
                    sign_a_d = is_signed && dividend[N-1];
                    sign_b_d = is_signed && divisor[N-1];
                    div0_d   = in_div0;
                    ovf_d    = in_ovf;
                    dvs_d    = mag_b;
                    quo_d    = mag_a;
                    rem_d    = '0;
                    cnt_d    = CW'(N - 1);
                    state_d  = (in_div0 || in_ovf) ? StFix : StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (!diff[N]) begin
                    rem_d = diff[N-1:0];
                    quo_d = {quo_q[N-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[N-1:0];
                    quo_d = {quo_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = StFix;
            end
            StFix: begin
                if (!flush) result_d = fix_out;
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == StRun) || (state_q == StFix);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule

// File: tb/tb_riscv_div_unit.sv
// Scoreboard bench for riscv_div_unit: stimulus pushes expected result and done cycle,
// a negedge monitor pops and compares whenever done is seen.
module tb_riscv_div_unit;
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend, divisor;
    logic        flush;
    logic        busy, done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [31:0] res_q[$];
    int          cyc_q[$];

    riscv_div_unit #(.N(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (res_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done: got done=1, expected no done (cycle %0d)", cyc);
            end else begin
                check("result", result, res_q.pop_front());
                check("done_cycle", 32'(cyc), 32'(cyc_q.pop_front()));
            end
        end
    end

    // Called right after a negedge; returns right after a later negedge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input int lat);
        int c0, nb, fb;
        bit seen;
        op = o; dividend = a; divisor = b; start = 1'b1;
        c0 = cyc;
        res_q.push_back(r);
        cyc_q.push_back(c0 + lat);
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); dividend = $urandom; divisor = $urandom;
        nb = 0; fb = -1; seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            #1;
            if (busy) begin
                nb++;
                if (fb < 0) fb = cyc - c0;
            end
            if (done) seen = 1'b1;
            @(negedge clk);
        end
        check("done_seen", 32'(seen), 32'd1);
        check("busy_cycles", 32'(nb), 32'(lat - 1));
        check("busy_first", 32'(fb), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && res_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(res_q.size()), 32'd0);
    endtask

    initial begin
        int c0;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(OP_DIV,  32'd20,          32'd3,  32'd6,          34);
        run_op(OP_REM,  -32'sd20,        32'd3,  32'hFFFF_FFFE,  34);
        run_op(OP_REMU, 32'hFFFF_FFFF,   32'd16, 32'h0000_000F,  34);

        run_op(OP_DIV,  32'd7, 32'd0, 32'hFFFF_FFFF, 2);
        run_op(OP_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 2);
        run_op(OP_REM,  32'd7, 32'd0, 32'd7,         2);
        run_op(OP_REMU, 32'd7, 32'd0, 32'd7,         2);
        run_op(OP_REM,  -32'sd7, 32'd0, 32'hFFFF_FFF9, 2);

        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);
        run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34);
        run_op(OP_DIV,  -32'sd100,     32'd7,         -32'sd14,      34);

        // Back-to-back: start held through cycles 0..40.
        c0 = cyc;
        op = OP_DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        res_q.push_back(32'd14); cyc_q.push_back(c0 + 34);
        res_q.push_back(32'd14); cyc_q.push_back(c0 + 68);
        for (int i = 1; i <= 41; i++) begin
            @(negedge clk);
            #1;
            if (cyc == c0 + 20) check("b2b_busy_run", 32'(busy), 32'd1);
            if (cyc == c0 + 34) check("b2b_busy_done", 32'(busy), 32'd0);
            if (cyc == c0 + 35) check("b2b_busy_second", 32'(busy), 32'd1);
        end
        start = 1'b0;
        drain();
        @(negedge clk);

        // Flush in cycle 10 kills the op; restart in cycle 12.
        c0 = cyc;
        op = OP_DIV; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_result_hold", result, 32'd14);
        @(negedge clk);
        op = OP_DIV; dividend = 32'd50; divisor = 32'd5;
        run_op(OP_DIV, 32'd50, 32'd5, 32'd10, 34);
        check("flush_restart_cycle", 32'(cyc - c0), 32'd47);

        // Asynchronous reset mid-RUN.
        c0 = cyc;
        op = OP_DIV; dividend = 32'd100; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 15) @(negedge clk);
        #2;
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_done", 32'(done), 32'd0);
        check("async_reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(OP_DIV, 32'd9, 32'd3, 32'd3, 34);

        drain();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
